// File: rtl/lookup_ram_pkg.sv
// Shared types and width helpers for the lane-assembling lookup RAM.
// Widths are derived here so the top and the bench agree on them.
package lookup_ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StFlush
  } state_e;

  function automatic int unsigned addr_w(int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned lane_w(int unsigned ratio);
    return $clog2(ratio);
  endfunction

  function automatic int unsigned row_w(int unsigned width, int unsigned ratio);
    return width * ratio;
  endfunction

endpackage

// File: rtl/lookup_word_ram_bank.sv
// Simple dual-port storage array: one write port, one registered read port.
// No reset so it maps onto block RAM; stale contents are masked by valid bits.
module lookup_word_ram_bank #(
  parameter int unsigned Width = 288,
  parameter int unsigned Depth = 1024,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lookup_word_ram.sv
// Collects RATIO narrow write beats into one wide word and commits it atomically;
// per-entry valid bits allow a bulk flush, and reads bypass a same-cycle commit.
module lookup_word_ram
  import lookup_ram_pkg::*;
#(
  parameter int unsigned WR_WIDTH = 36,
  parameter int unsigned RATIO    = 8,
  parameter int unsigned DEPTH    = 1024,
  parameter bit          RD_REG   = 1'b0,
  localparam int unsigned AW = addr_w(DEPTH),
  localparam int unsigned LW = lane_w(RATIO),
  localparam int unsigned RW = row_w(WR_WIDTH, RATIO)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [LW-1:0]       wr_lane,
  input  logic [WR_WIDTH-1:0] wr_data,
  output logic                wr_err,
  input  logic                flush_req,
  output logic                flush_busy,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic                rd_valid,
  output logic [RW-1:0]       rd_data,
  output logic                rd_hit
);

  localparam int unsigned SW = RW - WR_WIDTH;
  localparam logic [LW-1:0] LastLane = LW'(RATIO - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [AW-1:0]    fl_cnt_q, fl_cnt_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             err_q, err_d;
  logic             rdy_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [RW-1:0]    wdata;
  logic             accept, commit, byp;

  // rdy_q keeps wr_ready low until the first edge after reset release.
  assign wr_ready   = rdy_q && (state_q != StFlush);
  assign flush_busy = (state_q == StFlush);
  assign wr_err     = err_q;
  assign accept     = wr_valid && wr_ready;
  assign wdata      = {wr_data, stage_q};

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    fl_cnt_d = fl_cnt_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    commit   = 1'b0;
    if (flush_req && (state_q != StFlush)) begin
      state_d  = StFlush;
      fl_cnt_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (wr_lane == '0) begin
              waddr_d                 = wr_addr;
              stage_d[WR_WIDTH-1:0]   = wr_data;
              cnt_d                   = LW'(1);
              state_d                 = StCollect;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StCollect: begin
          if (accept) begin
            if (wr_lane != cnt_q) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else if (cnt_q == LastLane) begin
              commit  = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              stage_d[int'(cnt_q)*WR_WIDTH +: WR_WIDTH] = wr_data;
              cnt_d = cnt_q + LW'(1);
            end
          end
        end
        StFlush: begin
          valid_d[fl_cnt_q] = 1'b0;
          fl_cnt_d          = fl_cnt_q + AW'(1);
          if (fl_cnt_q == AW'(DEPTH - 1)) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (commit) begin
      valid_d[waddr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      waddr_q  <= '0;
      fl_cnt_q <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      fl_cnt_q <= fl_cnt_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
      valid_q  <= valid_d;
    end
  end

  // Read path, first stage. A commit to the read address is forwarded from wdata.
  logic          rv1_q, rv1_d, hit1_q, hit1_d, byp1_q, byp1_d;
  logic [RW-1:0] bdata_q, bdata_d, bank_rdata, rd1_data;

  assign byp = commit && (waddr_q == rd_addr);

  always_comb begin
    rv1_d   = rd_en;
    hit1_d  = rd_en && (state_q != StFlush) && (valid_q[rd_addr] || byp);
    byp1_d  = rd_en && byp;
    bdata_d = byp1_d ? wdata : bdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv1_q   <= 1'b0;
      hit1_q  <= 1'b0;
      byp1_q  <= 1'b0;
      bdata_q <= '0;
    end else begin
      rv1_q   <= rv1_d;
      hit1_q  <= hit1_d;
      byp1_q  <= byp1_d;
      bdata_q <= bdata_d;
    end
  end

  lookup_word_ram_bank #(
    .Width(RW),
    .Depth(DEPTH)
  ) u_bank (
    .clk_i  (clk),
    .we_i   (commit),
    .waddr_i(waddr_q),
    .wdata_i(wdata),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(bank_rdata)
  );

  assign rd1_data = !hit1_q ? '0 : (byp1_q ? bdata_q : bank_rdata);

  if (RD_REG) begin : g_out_reg
    logic          rv2_q, hit2_q;
    logic [RW-1:0] data2_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rv2_q   <= 1'b0;
        hit2_q  <= 1'b0;
        data2_q <= '0;
      end else begin
        rv2_q   <= rv1_q;
        hit2_q  <= hit1_q;
        data2_q <= rd1_data;
      end
    end

    assign rd_valid = rv2_q;
    assign rd_hit   = hit2_q;
    assign rd_data  = data2_q;
  end else begin : g_out_comb
    assign rd_valid = rv1_q;
    assign rd_hit   = hit1_q;
    assign rd_data  = rd1_data;
  end

endmodule

// File: tb/tb_lookup_word_ram.sv
// Directed bench for lookup_word_ram: a default instance plus a registered-output
// instance; read expectations are queued at issue time and checked on rd_valid.
module tb_lookup_word_ram;

  typedef struct {
    int           due;
    logic         hit;
    logic [287:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t q1[$];
  exp_t q2[$];

  // Default instance
  logic         wr_valid = 0, wr_ready, wr_err, flush_req = 0, flush_busy;
  logic [9:0]   wr_addr = 0, rd_addr = 0;
  logic [2:0]   wr_lane = 0;
  logic [35:0]  wr_data = 0;
  logic         rd_en = 0, rd_valid, rd_hit;
  logic [287:0] rd_data;

  // RD_REG=1, RATIO=4, DEPTH=64 instance
  logic         b_wr_valid = 0, b_wr_ready, b_wr_err, b_flush_req = 0, b_flush_busy;
  logic [5:0]   b_wr_addr = 0, b_rd_addr = 0;
  logic [1:0]   b_wr_lane = 0;
  logic [35:0]  b_wr_data = 0;
  logic         b_rd_en = 0, b_rd_valid, b_rd_hit;
  logic [143:0] b_rd_data;

  lookup_word_ram u_dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_data(wr_data), .wr_err(wr_err),
    .flush_req(flush_req), .flush_busy(flush_busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit)
  );

  lookup_word_ram #(.RD_REG(1'b1), .RATIO(4), .DEPTH(64)) u_dut2 (
    .clk(clk), .resetn(resetn), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_addr(b_wr_addr), .wr_lane(b_wr_lane), .wr_data(b_wr_data), .wr_err(b_wr_err),
    .flush_req(b_flush_req), .flush_busy(b_flush_busy), .rd_en(b_rd_en),
    .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_hit(b_rd_hit)
  );

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] word1(input int base);
    logic [287:0] w = '0;
    for (int k = 0; k < 8; k++) w[36*k +: 36] = 36'(base + k);
    return w;
  endfunction

  function automatic logic [287:0] word2(input int base);
    logic [287:0] w = '0;
    for (int k = 0; k < 4; k++) w[36*k +: 36] = 36'(base + k);
    return w;
  endfunction

  // Scoreboard monitors: pop one expectation per rd_valid, check arrival cycle too.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      chk("rd1_expected", 288'(q1.size() != 0), 288'(1));
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("rd1_latency", 288'(pcyc), 288'(e.due));
        chk("rd1_hit", 288'(rd_hit), 288'(e.hit));
        chk("rd1_data", rd_data, e.data);
      end
    end else begin
      chk("rd1_idle_out", {rd_hit, rd_data}, '0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rd_valid) begin
      chk("rd2_expected", 288'(q2.size() != 0), 288'(1));
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("rd2_latency", 288'(pcyc), 288'(e.due));
        chk("rd2_hit", 288'(b_rd_hit), 288'(e.hit));
        chk("rd2_data", 288'(b_rd_data), e.data);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    wr_valid = 0; rd_en = 0; flush_req = 0;
    b_wr_valid = 0; b_rd_en = 0; b_flush_req = 0;
  endtask

  task automatic set_beat(input int a, input int l, input int d);
    wr_valid = 1; wr_addr = 10'(a); wr_lane = 3'(l); wr_data = 36'(d);
  endtask

  task automatic set_rd(input int a, input logic h, input logic [287:0] d);
    rd_en = 1; rd_addr = 10'(a);
    q1.push_back('{due: pcyc + 1, hit: h, data: d});
  endtask

  task automatic set_beat2(input int a, input int l, input int d);
    b_wr_valid = 1; b_wr_addr = 6'(a); b_wr_lane = 2'(l); b_wr_data = 36'(d);
  endtask

  task automatic set_rd2(input int a, input logic h, input logic [287:0] d);
    b_rd_en = 1; b_rd_addr = 6'(a);
    q2.push_back('{due: pcyc + 2, hit: h, data: d});
  endtask

  task automatic write_word1(input int a, input int base);
    for (int k = 0; k < 8; k++) begin
      tick();
      set_beat(a, k, base + k);
    end
    tick();
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) tick();
    chk("reset_wr_ready", 288'(wr_ready), 288'(0));
    chk("reset_flush_busy", 288'(flush_busy), 288'(0));
    chk("reset_wr_err", 288'(wr_err), 288'(0));
    chk("reset_rd_valid", 288'(rd_valid), 288'(0));
    resetn = 1;
    #1 chk("ready_before_edge", 288'(wr_ready), 288'(0));
    tick();
    chk("ready_after_edge", 288'(wr_ready), 288'(1));

    // Full word to addr 5, then read it back
    write_word1(5, 'h100);
    set_rd(5, 1, word1('h100));

    // Lane skip 0,1,3 to addr 9
    tick(); set_beat(9, 0, 'h900);
    tick(); set_beat(9, 1, 'h901);
    tick(); set_beat(9, 3, 'h903);
    tick(); chk("err_lane_skip", 288'(wr_err), 288'(1));
    tick(); chk("err_one_cycle", 288'(wr_err), 288'(0));
    set_rd(9, 0, '0);
    tick(); set_beat(9, 2, 'h902);
    tick(); chk("err_idle_nonzero_lane", 288'(wr_err), 288'(1));

    // Commit to 12 with a same-cycle read (bypass); the read just before misses
    for (int k = 0; k < 7; k++) begin
      tick(); set_beat(12, k, 'h200 + k);
    end
    set_rd(12, 0, '0);
    tick(); set_beat(12, 7, 'h207); set_rd(12, 1, word1('h200));
    tick(); set_rd(12, 1, word1('h200));

    // Fill 0..3, flush, check duration and misses
    for (int a = 0; a < 4; a++) write_word1(a, 'h1000 * (a + 1));
    for (int a = 0; a < 4; a++) begin
      set_rd(a, 1, word1('h1000 * (a + 1)));
      tick();
    end
    flush_req = 1;
    tick();
    n = 0;
    while (flush_busy && n < 2000) begin
      n++;
      chk("flush_wr_ready", 288'(wr_ready), 288'(0));
      tick();
      if (n == 10) set_rd(5, 0, '0);
      if (n == 500) flush_req = 1;
    end
    chk("flush_busy_cycles", 288'(n), 288'(1024));
    for (int a = 0; a < 6; a++) begin
      set_rd(a, 0, '0);
      tick();
    end

    // Registered-output instance: back-to-back reads, 2-cycle latency
    for (int a = 0; a < 8; a++) begin
      for (int k = 0; k < 4; k++) begin
        tick(); set_beat2(a, k, 'h40 * (a + 1) + k);
      end
    end
    tick();
    for (int a = 0; a < 8; a++) begin
      set_rd2(a, 1, word2('h40 * (a + 1)));
      tick();
    end
    set_rd2(40, 0, '0);
    repeat (4) tick();

    // Reset mid-COLLECT with a hit read in flight
    write_word1(7, 'h700);
    for (int k = 0; k < 4; k++) begin
      tick(); set_beat(2, k, 'h300 + k);
    end
    set_rd(7, 1, word1('h700));
    tick();
    #2 resetn = 0;
    #1;
    chk("rst_rd_valid", 288'(rd_valid), 288'(0));
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_hit", 288'(rd_hit), 288'(0));
    chk("rst_wr_ready", 288'(wr_ready), 288'(0));
    chk("rst_wr_err", 288'(wr_err), 288'(0));
    chk("rst_flush_busy", 288'(flush_busy), 288'(0));
    repeat (2) tick();
    resetn = 1;
    tick();
    chk("ready_after_rerelease", 288'(wr_ready), 288'(1));
    set_rd(2, 0, '0);
    tick(); set_rd(7, 0, '0);
    write_word1(2, 'h500);
    set_rd(2, 1, word1('h500));
    repeat (4) tick();

    chk("q1_drained", 288'(q1.size()), 288'(0));
    chk("q2_drained", 288'(q2.size()), 288'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lookup_word_ram.md
LOOKUP_WORD_RAM -- requirements
Module: lookup_word_ram

Interface
REQ-001 Parameter WR_WIDTH, default 36, width of one write beat (lane) in bits.
REQ-002 Parameter RATIO, default 8, lanes per stored word; power of two, 2..16.
REQ-003 Parameter DEPTH, default 1024, stored words; power of two, >= 16.
REQ-004 Parameter RD_REG, default 0, adds one output register stage when 1.
REQ-005 Widths: AW = clog2(DEPTH), LW = clog2(RATIO), RW = WR_WIDTH*RATIO.
REQ-006 One clock; reset is asynchronous and active-low. Ports in order: clk  in  1  sole clock; resetn  in  1  asynchronous active-low reset.
REQ-007 wr_valid  in  1  write beat offered.
REQ-008 wr_ready  out  1  beat accepted when wr_valid && wr_ready.
REQ-009 wr_addr  in  AW  word address, sampled on lane-0 beat only.
REQ-010 wr_lane  in  LW  lane index of current beat.
REQ-011 wr_data  in  WR_WIDTH  beat data.
REQ-012 wr_err  out  1  one-cycle pulse on a lane-sequence violation.
REQ-013 flush_req  in  1  single-cycle request to invalidate all entries.
REQ-014 flush_busy  out  1  high while a flush is in progress.
REQ-015 rd_en  in  1  read request.
REQ-016 rd_addr  in  AW  read address.
REQ-017 rd_valid  out  1  rd_data/rd_hit qualified.
REQ-018 rd_data  out  RW  wide read word; lane k at bits [WR_WIDTH*(k+1)-1 -: WR_WIDTH].
REQ-019 rd_hit  out  1  addressed entry holds a committed, unflushed word.

Function
REQ-020 FSM states IDLE, COLLECT, FLUSH; SHALL reset to IDLE.
REQ-021 IDLE: accepted beat with wr_lane==0 SHALL latch wr_addr, store lane 0 in staging, set next-lane counter to 1, go to COLLECT.
REQ-022 IDLE: accepted beat with wr_lane!=0 SHALL be dropped and pulse wr_err next cycle.
REQ-023 COLLECT: accepted beat with wr_lane==counter SHALL be staged and the counter incremented.
REQ-024 COLLECT: beat with wr_lane!=counter SHALL discard the partial word, pulse wr_err, and return to IDLE without writing memory.
REQ-025 Accepting lane RATIO-1 in sequence SHALL write the full RW-bit word (staging plus current beat) to memory in that same clock edge, set the entry valid bit, and return to IDLE; memory never holds a partially updated word.
REQ-026 wr_ready SHALL be 1 in IDLE and COLLECT, 0 in FLUSH and during reset.
REQ-027 flush_req in any state SHALL abandon any partial word (no wr_err) and enter FLUSH next cycle.
REQ-028 FLUSH SHALL clear one valid bit per cycle, index 0 to DEPTH-1, and return to IDLE after exactly DEPTH cycles; flush_req during FLUSH SHALL be ignored.
REQ-029 flush_busy SHALL equal (state==FLUSH).
REQ-030 Read latency SHALL be 1+RD_REG cycles from rd_en to rd_valid; one read per cycle, fully pipelined, no backpressure.
REQ-031 rd_hit SHALL be the valid bit at the read sample edge; rd_hit SHALL be 0 for reads issued while flush_busy is high.
REQ-032 Read of the address being committed in the same cycle SHALL return the new word with rd_hit=1 (write-first bypass).
REQ-033 rd_data SHALL be all-zero whenever rd_hit=0 or rd_valid=0.
REQ-034 Simultaneous commit and flush_req: flush wins; commit SHALL NOT occur.

Reset
REQ-035 Asserting resetn low SHALL immediately force state IDLE, counter 0, all valid bits 0, wr_err 0, rd_valid 0, rd_data 0, rd_hit 0, flush_busy 0, wr_ready 0.
REQ-036 Reset mid-COLLECT or mid-FLUSH SHALL discard progress; memory data content is not reset and is masked by valid bits.
REQ-037 wr_ready SHALL rise on the first clk edge after resetn deasserts.

Structure
REQ-038 Shared package lookup_ram_pkg SHALL hold the FSM state enum and the width helper functions (AW, LW, RW derivation).
REQ-039 Data storage SHALL be a sub-module lookup_word_ram_bank: simple dual-port, RW wide, DEPTH deep, synchronous read, no reset, inferred block RAM; valid bits SHALL be flops in the top module.

Verification
REQ-040 Defaults; write lanes 0..7 of 0x100+k to addr 5, then read 5 -> rd_valid after 1 cycle, rd_hit=1, lane k = 0x100+k.
REQ-041 Lanes 0,1,3 to addr 9 -> wr_err pulse after lane 3, read 9 -> rd_hit=0, rd_data=0.
REQ-042 Commit lane 7 to addr 12 with rd_en/rd_addr=12 same cycle -> new word returned, rd_hit=1.
REQ-043 Fill addrs 0..3, pulse flush_req -> flush_busy high exactly 1024 cycles, wr_ready=0 throughout, reads of 0..3 afterwards -> rd_hit=0.
REQ-044 RD_REG=1, RATIO=4, DEPTH=64: back-to-back reads of 8 addresses -> rd_valid 2 cycles after each rd_en, no gaps.
REQ-045 resetn low after lane 3 of a word to addr 2 -> outputs per REQ-035 immediately; after release, read 2 -> rd_hit=0.
